// File: rtl/load_store_unit_if.sv
// Bus between the pipeline, the load/store unit and the word-only data memory.
// The master side is the pipeline plus memory; the slave side is the LSU.
interface load_store_unit_if #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_fault;
  logic [ADDR_BITS-1:0]  mem_address;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_write, mem_write_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_write, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a word-only, 1-cycle-latency sync-read data memory.
// Sub-word stores are done as read-modify-write; one request in flight.
//
// state       | meaning
// S_IDLE      | accept requests; SW writes directly, faults respond immediately
// S_LOAD_WAIT | read data arriving; extract and extend the addressed lane
// S_RMW_MERGE | read data arriving; merge store byte/half into the word
// S_RMW_WRITE | write the merged word back to the latched address
module load_store_unit #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_RMW_MERGE,
    S_RMW_WRITE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [2:0]            r_funct3;
  logic [15:0]           r_wdata;
  logic [DATA_WIDTH-1:0] r_merged;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_fault;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_misalign;
  logic                  w_fault;
  logic                  w_is_sw;
  logic                  w_req_ready;
  logic                  w_mem_write;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [ADDR_BITS-1:0]  w_mem_addr;
  logic [4:0]            w_shift;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_ins;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept = bus.req_valid & w_req_ready;

  always_comb begin
    w_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~bus.req_store;
      default:                w_legal = 1'b0;
    endcase
    w_misalign = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                 ((bus.req_funct3[1:0] == 2'b10) & (|bus.req_addr[1:0]));
    w_fault    = ~w_legal | w_misalign;
    w_is_sw    = bus.req_store & (bus.req_funct3 == 3'b010) & ~w_fault;
  end

  // Lane extraction and merge both work on the latched address and the word now on mem_read_data.
  assign w_shift = {r_addr[1:0], 3'b000};
  assign w_lane  = bus.mem_read_data >> w_shift;

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  always_comb begin
    if (r_funct3[0]) begin
      w_mask = DATA_WIDTH'(16'hFFFF) << w_shift;
      w_ins  = DATA_WIDTH'(r_wdata) << w_shift;
    end else begin
      w_mask = DATA_WIDTH'(8'hFF) << w_shift;
      w_ins  = DATA_WIDTH'(r_wdata[7:0]) << w_shift;
    end
    w_merged = (bus.mem_read_data & ~w_mask) | w_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_mem_write = 1'b0;
    w_mem_wdata = '0;
    w_mem_addr  = r_addr;
    case (r_state)
      S_IDLE: begin
        w_req_ready = rst_n;
        w_mem_addr  = bus.req_addr;
        if (w_accept && !w_fault) begin
          if (!bus.req_store)     w_next = S_LOAD_WAIT;
          else if (w_is_sw) begin
            w_mem_write = 1'b1;
            w_mem_wdata = bus.req_wdata;
          end else                w_next = S_RMW_MERGE;
        end
      end
      S_LOAD_WAIT: w_next = S_IDLE;
      S_RMW_MERGE: w_next = S_RMW_WRITE;
      S_RMW_WRITE: begin
        w_mem_write = 1'b1;
        w_mem_wdata = r_merged;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_merged     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.req_addr;
            r_funct3 <= bus.req_funct3;
            r_wdata  <= bus.req_wdata[15:0];
            if (w_fault || w_is_sw) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_fault <= w_fault;
            end
          end
        end
        S_LOAD_WAIT: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_resp_fault <= 1'b0;
        end
        S_RMW_MERGE: r_merged <= w_merged;
        S_RMW_WRITE: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.mem_address    = w_mem_addr;
  assign bus.mem_write      = w_mem_write;
  assign bus.mem_write_data = w_mem_wdata;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_fault     = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// transaction-level memory/response model.
module tb_load_store_unit;
  localparam int AB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_BITS(AB), .DATA_WIDTH(32)) bus();
  load_store_unit #(.ADDR_BITS(AB), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Data memory: sync read, one-cycle latency, plus a preload port for the bench.
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        fill = 1'b1;
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i) * 32'h9E3779B1;
    end else begin
      bus.mem_read_data <= mem[bus.mem_address[11:2]];
      if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
      if (pre_we)        mem[pre_addr[11:2]] <= pre_data;
    end
  end

  int wr_cnt = 0;
  int resp_cnt = 0;
  int wd_err = 0;
  always @(negedge clk) begin
    if (bus.mem_write) wr_cnt++;
    if (bus.resp_valid) resp_cnt++;
    if (!bus.mem_write && bus.mem_write_data != 32'h0) wd_err++;
  end

  // Reference: what a request should return and do to memory, from the ISA rules.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [11:0] a,
                                input logic [31:0] wd, output bit flt, output logic [31:0] rd,
                                output int lat, output int nwr);
    longint one = 1;
    longint w, v, bw, bn;
    int size, o;
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << (f3 % 4);
    flt   = !legal || (int'(a) % size != 0);
    rd = 32'h0; nwr = 0; lat = 1;
    if (flt) return;
    o = int'(a) % 4;
    w = longint'(ref_mem[int'(a) / 4]);
    if (!st) begin
      v = (w >> (8 * o)) % (one << (8 * size));
      if (f3 < 3'd4 && v >= (one << (8 * size - 1))) v = v - (one << (8 * size));
      rd  = v[31:0];
      lat = 2;
    end else begin
      nwr = 1;
      lat = (size == 4) ? 1 : 3;
      v = w;
      for (int b = 0; b < size; b++) begin
        bw = (w >> (8 * (o + b))) & 255;
        bn = (longint'(wd) >> (8 * b)) & 255;
        v  = v - (bw << (8 * (o + b))) + (bn << (8 * (o + b)));
      end
      ref_mem[int'(a) / 4] = v[31:0];
    end
  endfunction

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[int'(a) / 4] = d;
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] wd, input string tag);
    bit eflt;
    logic [31:0] erd;
    int elat, enwr;
    int lat, pulses, nwr, wk;
    logic [31:0] grd;
    logic gflt;
    bit busy_ok;
    model(st, f3, a, wd, eflt, erd, elat, enwr);
    lat = 0; pulses = 0; nwr = 0; wk = -1; busy_ok = 1'b1; grd = '0; gflt = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (bus.mem_write) begin nwr++; wk = k; end
      if (k == 0) check_eq({tag, " ready"}, 32'(bus.req_ready), 32'h1);
      if (k >= 1 && bus.resp_valid) begin
        pulses++;
        if (lat == 0) begin lat = k; grd = bus.resp_rdata; gflt = bus.resp_fault; end
      end
      if (k >= 1 && k < elat && bus.req_ready) busy_ok = 1'b0;
      if (k == 0) begin
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
      end
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(elat));
    check_eq({tag, " rdata"}, grd, erd);
    check_eq({tag, " fault"}, 32'(gflt), 32'(eflt));
    check_eq({tag, " pulses"}, 32'(pulses), 32'h1);
    check_eq({tag, " writes"}, 32'(nwr), 32'(enwr));
    if (enwr == 1) check_eq({tag, " write cycle"}, 32'(wk), 32'(elat - 1));
    check_eq({tag, " busy"}, 32'(busy_ok), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    bit f_d; logic [31:0] r_d; int l_d, n_d;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    @(posedge clk); #1;
    fill = 1'b0;
    @(negedge clk);
    check_eq("rst ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("rst rdata", bus.resp_rdata, 32'h0);
    check_eq("rst fault", 32'(bus.resp_fault), 32'h0);
    check_eq("rst mem_write", 32'(bus.mem_write), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, "sw");
    do_req(1'b0, 3'b010, 12'h010, 32'h0, "lw");
    check_eq("lw data const", ref_mem[4], 32'hDEADBEEF);

    poke(12'h020, 32'h80FF7F01);
    do_req(1'b0, 3'b000, 12'h022, 32'h0, "lb");
    do_req(1'b0, 3'b100, 12'h023, 32'h0, "lbu");
    do_req(1'b0, 3'b001, 12'h022, 32'h0, "lh");
    do_req(1'b0, 3'b101, 12'h020, 32'h0, "lhu");

    poke(12'h030, 32'h11223344);
    do_req(1'b1, 3'b000, 12'h031, 32'h000000AA, "sb");
    check_eq("sb word", mem[12], 32'h1122AA44);
    do_req(1'b1, 3'b001, 12'h032, 32'h0000BEEF, "sh");
    check_eq("sh word", mem[12], 32'hBEEFAA44);

    do_req(1'b0, 3'b010, 12'h041, 32'h0, "lw misalign");
    do_req(1'b1, 3'b001, 12'h043, 32'h12345678, "sh misalign");
    do_req(1'b0, 3'b011, 12'h044, 32'h0, "f3 011");
    do_req(1'b1, 3'b100, 12'h048, 32'h12345678, "store f3 100");

    // Four SW requests on consecutive cycles.
    w0 = wr_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    for (int j = 0; j < 4; j++) begin
      bus.req_addr  = 12'h060 + 12'(4 * j);
      bus.req_wdata = $urandom;
      model(1'b1, 3'b010, bus.req_addr, bus.req_wdata, f_d, r_d, l_d, n_d);
      @(negedge clk);
      check_eq("b2b ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("b2b writes", 32'(wr_cnt - w0), 32'h4);
    check_eq("b2b pulses", 32'(resp_cnt - r0), 32'h4);

    // Reset in the middle of a read-modify-write.
    poke(12'h050, 32'hCAFEF00D);
    w0 = wr_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 12'h051; bus.req_wdata = 32'h0000005A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort ready", 32'(bus.req_ready), 32'h0);
    check_eq("abort mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("abort resp_valid", 32'(bus.resp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort writes", 32'(wr_cnt - w0), 32'h0);
    check_eq("abort pulses", 32'(resp_cnt - r0), 32'h0);
    check_eq("abort word", mem[20], 32'hCAFEF00D);
    check_eq("abort ready after", 32'(bus.req_ready), 32'h1);

    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             12'h100 + 12'($urandom_range(0, 63)), $urandom, "rand");
    end

    for (int i = 0; i < 128; i++) check_eq($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    check_eq("wdata zero when idle", 32'(wd_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
